// File: rtl/wl_pkg.sv
// ---------------------------------------------------------------------------
// wl_pkg
// Shared types and helpers for the wirelength evaluator.
//   wl_state_e : evaluator FSM states, one cycle each
//   WL_DW      : width the helper functions operate on (matches default DW)
//   UNPLACED   : coordinate value marking a node that has no position yet
//   abs_dw     : two's-complement absolute value
//   ceil_half  : ceil(d/2) for a non-negative distance
// ---------------------------------------------------------------------------
package wl_pkg;

    localparam int WL_DW    = 32;
    localparam int UNPLACED = -1;

    typedef enum logic [3:0] {
        S_IDLE,
        S_EDGE,
        S_EWAIT,
        S_RDA,
        S_AWAIT,
        S_RDB,
        S_BWAIT,
        S_DIFF,
        S_ACC,
        S_DONE
    } wl_state_e;

    // Negating the most negative value wraps back to itself, which is the
    // intended modulo-2^DW behaviour.
    function automatic logic [WL_DW-1:0] abs_dw(input logic [WL_DW-1:0] x);
        return x[WL_DW-1] ? (~x + WL_DW'(1)) : x;
    endfunction

    function automatic logic [WL_DW-1:0] ceil_half(input logic [WL_DW-1:0] d);
        return (d >> 1) + {{(WL_DW-1){1'b0}}, d[0]};
    endfunction

endpackage

// File: rtl/wl_accum.sv
// ---------------------------------------------------------------------------
// wl_accum
// DIFF/ACC datapath of the wirelength evaluator: registers |dx|, |dy| and the
// unplaced flag in the DIFF cycle, then updates the accumulators in ACC.
// Optional build macro: WL_HIST_EN adds four distance-histogram counters.
// Ports:
//   clk, reset        : clock, asynchronous active-low reset
//   clr_i             : clear all accumulators (accepted start)
//   diff_en_i         : DIFF cycle, capture distances of the current edge
//   acc_en_i          : ACC cycle, fold the captured distances into the sums
//   ax_i, ay_i        : endpoint A coordinates
//   bx_i, by_i        : endpoint B coordinates
//   sum_o             : sum of (|dx|+|dy|-1)
//   sum_1hop_o        : sum of (ceil(|dx|/2)+ceil(|dy|/2)-1)
//   unplaced_cnt_o    : edges skipped for an unplaced endpoint
//   hist_o            : (WL_HIST_EN) counts of distance 1, 2, 3, >3
// ---------------------------------------------------------------------------
module wl_accum
    import wl_pkg::*;
#(
    parameter int DW = WL_DW   // helper functions are WL_DW wide; keep DW <= WL_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr_i,
    input  logic          diff_en_i,
    input  logic          acc_en_i,
    input  logic [DW-1:0] ax_i,
    input  logic [DW-1:0] ay_i,
    input  logic [DW-1:0] bx_i,
    input  logic [DW-1:0] by_i,
    output logic [DW-1:0] sum_o,
    output logic [DW-1:0] sum_1hop_o,
    output logic [DW-1:0] unplaced_cnt_o
`ifdef WL_HIST_EN
    ,
    output logic [3:0][DW-1:0] hist_o
`endif
);

    localparam logic [DW-1:0] ONE = DW'(1);
    localparam logic [DW-1:0] UNPL = DW'(UNPLACED);

    logic [DW-1:0] adx_q, ady_q, adx_d, ady_d;
    logic          skip_q, skip_d;
    logic [DW-1:0] sum_q, sum_d;
    logic [DW-1:0] s1_q, s1_d;
    logic [DW-1:0] unp_q, unp_d;

    always_comb begin
        // Subtraction wraps; its bit pattern is the signed difference.
        adx_d  = DW'(abs_dw(WL_DW'(ax_i - bx_i)));
        ady_d  = DW'(abs_dw(WL_DW'(ay_i - by_i)));
        skip_d = (ax_i == UNPL) | (ay_i == UNPL) | (bx_i == UNPL) | (by_i == UNPL);

        sum_d = sum_q;
        s1_d  = s1_q;
        unp_d = unp_q;
        if (clr_i) begin
            sum_d = '0;
            s1_d  = '0;
            unp_d = '0;
        end else if (acc_en_i) begin
            if (skip_q) begin
                unp_d = unp_q + ONE;
            end else begin
                // Coincident endpoints legitimately contribute -1.
                sum_d = sum_q + adx_q + ady_q - ONE;
                s1_d  = s1_q + DW'(ceil_half(WL_DW'(adx_q)))
                             + DW'(ceil_half(WL_DW'(ady_q))) - ONE;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            adx_q  <= '0;
            ady_q  <= '0;
            skip_q <= 1'b0;
            sum_q  <= '0;
            s1_q   <= '0;
            unp_q  <= '0;
        end else begin
            if (diff_en_i) begin
                adx_q  <= adx_d;
                ady_q  <= ady_d;
                skip_q <= skip_d;
            end
            sum_q <= sum_d;
            s1_q  <= s1_d;
            unp_q <= unp_d;
        end
    end

    assign sum_o          = sum_q;
    assign sum_1hop_o     = s1_q;
    assign unplaced_cnt_o = unp_q;

`ifdef WL_HIST_EN
    logic [DW-1:0] dist;
    assign dist = adx_q + ady_q;

    // Bins 0..2 count distance gi+1 exactly; bin 3 counts anything above 3.
    // Distance 0 falls in no bin.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_hist
            logic [DW-1:0] cnt_q;
            logic          hit;
            assign hit = (gi < 3) ? (dist == DW'(gi + 1)) : (dist > DW'(3));

            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_q <= '0;
                end else if (clr_i) begin
                    cnt_q <= '0;
                end else if (acc_en_i && !skip_q && hit) begin
                    cnt_q <= cnt_q + ONE;
                end
            end

            assign hist_o[gi] = cnt_q;
        end
    endgenerate
`endif

endmodule

// File: rtl/wirelength_eval.sv
// ---------------------------------------------------------------------------
// wirelength_eval
// Post-placement cost evaluator. Walks the edge list, fetches both endpoint
// positions and accumulates Manhattan and 1-hop wirelength sums.
// Optional build macro: WL_HIST_EN adds hist_d1/hist_d2/hist_d3/hist_dgt3.
// Ports:
//   clk, reset         : clock, asynchronous active-low reset
//   start              : one-cycle pulse, accepted only in IDLE
//   busy, done         : busy outside IDLE; done pulses once results are final
//   edge_re, edge_addr : edge ROM strobe/address (A and B ROMs share them)
//   edge_a, edge_b     : endpoint node indices of the addressed edge
//   pos_re, pos_addr   : position RAM strobe/address (X and Y share them)
//   pos_x, pos_y       : node coordinates, -1 = unplaced
//   sum, sum_1hop      : accumulated costs (signed, wrapping)
//   unplaced_cnt       : edges skipped for an unplaced endpoint
// Memory timing: a state issues its strobe on the clock edge that leaves it,
// so the strobe is visible in the following (wait) state, the memory
// registers its read at the end of that cycle, and the data is consumed by
// the state two cycles after the issuing one.
// ---------------------------------------------------------------------------
module wirelength_eval
    import wl_pkg::*;
#(
    parameter int N_EDGE  = 71,
    parameter int EDGE_AW = 9,
    parameter int POS_AW  = 7,
    parameter int DW      = WL_DW
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    output logic               busy,
    output logic               done,
    output logic               edge_re,
    output logic [EDGE_AW-1:0] edge_addr,
    input  logic [DW-1:0]      edge_a,
    input  logic [DW-1:0]      edge_b,
    output logic               pos_re,
    output logic [POS_AW-1:0]  pos_addr,
    input  logic [DW-1:0]      pos_x,
    input  logic [DW-1:0]      pos_y,
    output logic [DW-1:0]      sum,
    output logic [DW-1:0]      sum_1hop,
    output logic [DW-1:0]      unplaced_cnt
`ifdef WL_HIST_EN
    ,
    output logic [DW-1:0]      hist_d1,
    output logic [DW-1:0]      hist_d2,
    output logic [DW-1:0]      hist_d3,
    output logic [DW-1:0]      hist_dgt3
`endif
);

    localparam int LAST = N_EDGE - 1;

    wl_state_e          state_q;
    logic [EDGE_AW-1:0] i_q;
    logic [POS_AW-1:0]  b_idx_q;
    logic [DW-1:0]      ax_q, ay_q;
    logic               edge_re_q, pos_re_q, done_q, busy_q;
    logic [EDGE_AW-1:0] edge_addr_q;
    logic [POS_AW-1:0]  pos_addr_q;

    logic accept;
    assign accept = (state_q == S_IDLE) && start;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= S_IDLE;
            i_q         <= '0;
            b_idx_q     <= '0;
            ax_q        <= '0;
            ay_q        <= '0;
            edge_re_q   <= 1'b0;
            edge_addr_q <= '0;
            pos_re_q    <= 1'b0;
            pos_addr_q  <= '0;
            done_q      <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            // Strobes and done are single-cycle pulses by default.
            edge_re_q <= 1'b0;
            pos_re_q  <= 1'b0;
            done_q    <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        i_q    <= '0;
                        busy_q <= 1'b1;
                        if (N_EDGE == 0) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= S_EDGE;
                        end
                    end
                end
                S_EDGE: begin
                    edge_re_q   <= 1'b1;
                    edge_addr_q <= i_q;
                    state_q     <= S_EWAIT;
                end
                S_EWAIT: state_q <= S_RDA;
                S_RDA: begin
                    b_idx_q    <= edge_b[POS_AW-1:0];
                    pos_re_q   <= 1'b1;
                    pos_addr_q <= edge_a[POS_AW-1:0];
                    state_q    <= S_AWAIT;
                end
                S_AWAIT: state_q <= S_RDB;
                S_RDB: begin
                    ax_q       <= pos_x;
                    ay_q       <= pos_y;
                    pos_re_q   <= 1'b1;
                    pos_addr_q <= b_idx_q;
                    state_q    <= S_BWAIT;
                end
                S_BWAIT: state_q <= S_DIFF;
                S_DIFF:  state_q <= S_ACC;
                S_ACC: begin
                    i_q <= i_q + EDGE_AW'(1);
                    if (int'(i_q) == LAST) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end else begin
                        state_q <= S_EDGE;
                    end
                end
                S_DONE: begin
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign edge_re   = edge_re_q;
    assign edge_addr = edge_addr_q;
    assign pos_re    = pos_re_q;
    assign pos_addr  = pos_addr_q;

    // Node indices only use the low POS_AW bits of the edge ROM words.
    logic unused_hi_bits;
    assign unused_hi_bits = ^{edge_a[DW-1:POS_AW], edge_b[DW-1:POS_AW]};

`ifdef WL_HIST_EN
    logic [3:0][DW-1:0] hist_w;
    assign hist_d1   = hist_w[0];
    assign hist_d2   = hist_w[1];
    assign hist_d3   = hist_w[2];
    assign hist_dgt3 = hist_w[3];
`endif

    wl_accum #(
        .DW(DW)
    ) u_accum (
        .clk           (clk),
        .reset         (reset),
        .clr_i         (accept),
        .diff_en_i     (state_q == S_DIFF),
        .acc_en_i      (state_q == S_ACC),
        .ax_i          (ax_q),
        .ay_i          (ay_q),
        .bx_i          (pos_x),
        .by_i          (pos_y),
        .sum_o         (sum),
        .sum_1hop_o    (sum_1hop),
        .unplaced_cnt_o(unplaced_cnt)
`ifdef WL_HIST_EN
        ,
        .hist_o        (hist_w)
`endif
    );

endmodule

// File: tb/tb_wirelength_eval.sv
// ---------------------------------------------------------------------------
// tb_wirelength_eval
// Five evaluator instances (N_EDGE = 1, 2, 71, 5, 0), each with its own
// edge ROM / position RAM models (registered read on the strobe).
// Build with WL_HIST_EN defined to include the histogram outputs.
// ---------------------------------------------------------------------------
module tb_wirelength_eval;

    localparam int NCFG = 5;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic        start_r  [NCFG];
    logic        busy_w   [NCFG];
    logic        done_w   [NCFG];
    logic        ere_w    [NCFG];
    logic        pre_w    [NCFG];
    logic [8:0]  eaddr_w  [NCFG];
    logic [6:0]  paddr_w  [NCFG];
    logic [31:0] ea_q     [NCFG];
    logic [31:0] eb_q     [NCFG];
    logic [31:0] px_q     [NCFG];
    logic [31:0] py_q     [NCFG];
    logic [31:0] sum_w    [NCFG];
    logic [31:0] s1_w     [NCFG];
    logic [31:0] unp_w    [NCFG];
`ifdef WL_HIST_EN
    logic [31:0] h1_w     [NCFG];
    logic [31:0] h2_w     [NCFG];
    logic [31:0] h3_w     [NCFG];
    logic [31:0] h4_w     [NCFG];
`endif

    logic [31:0] ea_mem [NCFG][512];
    logic [31:0] eb_mem [NCFG][512];
    logic [31:0] px_mem [NCFG][128];
    logic [31:0] py_mem [NCFG][128];
    int          ere_cnt [NCFG];
    int          pre_cnt [NCFG];

    int n_cmp = 0;
    int n_bad = 0;

    generate
        for (genvar gi = 0; gi < NCFG; gi++) begin : g_dut
            localparam int NE = (gi == 0) ? 1 : (gi == 1) ? 2 : (gi == 2) ? 71 : (gi == 3) ? 5 : 0;

            wirelength_eval #(
                .N_EDGE (NE),
                .EDGE_AW(9),
                .POS_AW (7),
                .DW     (32)
            ) u_dut (
                .clk         (clk),
                .reset       (reset),
                .start       (start_r[gi]),
                .busy        (busy_w[gi]),
                .done        (done_w[gi]),
                .edge_re     (ere_w[gi]),
                .edge_addr   (eaddr_w[gi]),
                .edge_a      (ea_q[gi]),
                .edge_b      (eb_q[gi]),
                .pos_re      (pre_w[gi]),
                .pos_addr    (paddr_w[gi]),
                .pos_x       (px_q[gi]),
                .pos_y       (py_q[gi]),
                .sum         (sum_w[gi]),
                .sum_1hop    (s1_w[gi]),
                .unplaced_cnt(unp_w[gi])
`ifdef WL_HIST_EN
                ,
                .hist_d1     (h1_w[gi]),
                .hist_d2     (h2_w[gi]),
                .hist_d3     (h3_w[gi]),
                .hist_dgt3   (h4_w[gi])
`endif
            );

            always @(posedge clk) begin
                if (ere_w[gi] === 1'b1) begin
                    ea_q[gi]    <= ea_mem[gi][eaddr_w[gi]];
                    eb_q[gi]    <= eb_mem[gi][eaddr_w[gi]];
                    ere_cnt[gi] <= ere_cnt[gi] + 1;
                end
                if (pre_w[gi] === 1'b1) begin
                    px_q[gi]    <= px_mem[gi][paddr_w[gi]];
                    py_q[gi]    <= py_mem[gi][paddr_w[gi]];
                    pre_cnt[gi] <= pre_cnt[gi] + 1;
                end
            end
        end
    endgenerate

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d (0x%h) expected %0d (0x%h)",
                   tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    // Pulse start on instance k, wait (bounded) for done, check timing,
    // pulse shape and the number of memory strobes issued.
    task automatic run(input int k, input int ne, input string tag);
        int ec0, pc0, lat;
        ec0 = ere_cnt[k];
        pc0 = pre_cnt[k];
        start_r[k] = 1'b1;
        tick();
        start_r[k] = 1'b0;
        lat = 1;
        while (done_w[k] !== 1'b1 && lat < 8 * ne + 40) begin
            tick();
            lat++;
        end
        chk({tag, " latency"}, lat, 8 * ne + 1);
        chk({tag, " busy at done"}, 32'(busy_w[k]), 32'd1);
        tick();
        chk({tag, " done pulse width"}, 32'(done_w[k]), 32'd0);
        chk({tag, " busy idle"}, 32'(busy_w[k]), 32'd0);
        chk({tag, " edge strobes"}, ere_cnt[k] - ec0, ne);
        chk({tag, " pos strobes"}, pre_cnt[k] - pc0, 2 * ne);
        $display("run %s: sum=%0d sum_1hop=%0d unplaced=%0d latency=%0d",
                 tag, $signed(sum_w[k]), $signed(s1_w[k]), unp_w[k], lat);
    endtask

    // Independent reference: integer arithmetic straight from the cost formulas.
    task automatic model(input int k, input int ne, output int es, output int e1, output int eu);
        int a, b, xa, ya, xb, yb, dx, dy;
        es = 0; e1 = 0; eu = 0;
        for (int e = 0; e < ne; e++) begin
            a  = int'(ea_mem[k][e]) % 128;
            b  = int'(eb_mem[k][e]) % 128;
            xa = int'(px_mem[k][a]);
            ya = int'(py_mem[k][a]);
            xb = int'(px_mem[k][b]);
            yb = int'(py_mem[k][b]);
            if (xa == -1 || ya == -1 || xb == -1 || yb == -1) begin
                eu++;
            end else begin
                dx = (xa > xb) ? xa - xb : xb - xa;
                dy = (ya > yb) ? ya - yb : yb - ya;
                es += dx + dy - 1;
                e1 += (dx + 1) / 2 + (dy + 1) / 2 - 1;
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, ndone, es, e1, eu, guard;

        reset = 1'b0;
        for (int k = 0; k < NCFG; k++) begin
            start_r[k] = 1'b0;
            for (int n = 0; n < 512; n++) begin
                ea_mem[k][n] = '0;
                eb_mem[k][n] = '0;
            end
            for (int n = 0; n < 128; n++) begin
                px_mem[k][n] = '0;
                py_mem[k][n] = '0;
            end
        end

        // cfg0 (1 edge): (3,5), pos3=(0,0), pos5=(7,7)
        ea_mem[0][0] = 32'd3; eb_mem[0][0] = 32'd5;
        px_mem[0][5] = 32'd7; py_mem[0][5] = 32'd7;
        // cfg1 (2 edges): (0,1),(1,2)
        ea_mem[1][0] = 32'd0; eb_mem[1][0] = 32'd1;
        ea_mem[1][1] = 32'd1; eb_mem[1][1] = 32'd2;
        px_mem[1][0] = 32'd2; py_mem[1][0] = 32'd2;
        px_mem[1][1] = 32'd2; py_mem[1][1] = 32'd3;
        px_mem[1][2] = 32'd5; py_mem[1][2] = 32'd2;
        // cfg2 (71 edges): pseudo-random pattern, includes unplaced nodes
        for (int n = 0; n < 128; n++) begin
            px_mem[2][n] = 32'((n * 13) % 50 - 20);
            py_mem[2][n] = 32'((n * 29) % 40 - 15);
        end
        for (int e = 0; e < 71; e++) begin
            ea_mem[2][e] = 32'(e);
            eb_mem[2][e] = 32'((e * 7 + 3) % 128);
        end
        // cfg3 (5 edges): distances 1,1,2,4,0
        ea_mem[3][0] = 32'd0; eb_mem[3][0] = 32'd1;
        ea_mem[3][1] = 32'd0; eb_mem[3][1] = 32'd2;
        ea_mem[3][2] = 32'd0; eb_mem[3][2] = 32'd3;
        ea_mem[3][3] = 32'd0; eb_mem[3][3] = 32'd4;
        ea_mem[3][4] = 32'd1; eb_mem[3][4] = 32'd1;
        px_mem[3][1] = 32'd1;
        py_mem[3][2] = 32'd1;
        px_mem[3][3] = 32'd1; py_mem[3][3] = 32'd1;
        px_mem[3][4] = 32'd3; py_mem[3][4] = 32'd1;

        // Reset state
        repeat (3) tick();
        chk("reset sum", sum_w[0], 32'd0);
        chk("reset sum_1hop", s1_w[0], 32'd0);
        chk("reset unplaced", unp_w[0], 32'd0);
        chk("reset busy", 32'(busy_w[0]), 32'd0);
        chk("reset done", 32'(done_w[0]), 32'd0);
        chk("reset edge_re", 32'(ere_w[2]), 32'd0);
        chk("reset pos_re", 32'(pre_w[2]), 32'd0);
        chk("reset edge_addr", 32'(eaddr_w[2]), 32'd0);
`ifdef WL_HIST_EN
        chk("reset hist_d1", h1_w[3], 32'd0);
`endif
        reset = 1'b1;
        tick();

        // Single edge, golden values from hand calculation
        run(0, 1, "n1");
        chk("n1 sum", sum_w[0], 32'd13);
        chk("n1 sum_1hop", s1_w[0], 32'd7);
        chk("n1 unplaced", unp_w[0], 32'd0);
        repeat (5) tick();
        chk("n1 hold sum", sum_w[0], 32'd13);

        // Endpoint A unplaced (x = -1)
        px_mem[0][3] = 32'hFFFF_FFFF;
        run(0, 1, "skipA");
        chk("skipA unplaced", unp_w[0], 32'd1);
        chk("skipA sum", sum_w[0], 32'd0);
        chk("skipA sum_1hop", s1_w[0], 32'd0);
        px_mem[0][3] = 32'd0;

        // Endpoint B unplaced (y = -1)
        py_mem[0][5] = 32'hFFFF_FFFF;
        run(0, 1, "skipB");
        chk("skipB unplaced", unp_w[0], 32'd1);
        chk("skipB sum", sum_w[0], 32'd0);
        py_mem[0][5] = 32'd7;

        // Coincident endpoints contribute -1 to both sums
        eb_mem[0][0] = 32'd3;
        run(0, 1, "zero");
        chk("zero sum", sum_w[0], 32'hFFFF_FFFF);
        chk("zero sum_1hop", s1_w[0], 32'hFFFF_FFFF);
        chk("zero unplaced", unp_w[0], 32'd0);

        // Two edges
        run(1, 2, "n2");
        chk("n2 sum", sum_w[1], 32'd3);
        chk("n2 sum_1hop", s1_w[1], 32'd2);

        // start re-pulsed mid-run is ignored
        start_r[1] = 1'b1;
        tick();
        start_r[1] = 1'b0;
        lat = 1;
        repeat (4) begin tick(); lat++; end
        start_r[1] = 1'b1;
        tick();
        lat++;
        start_r[1] = 1'b0;
        while (done_w[1] !== 1'b1 && lat < 60) begin tick(); lat++; end
        chk("repulse latency", lat, 17);
        ndone = 0;
        repeat (30) begin
            tick();
            if (done_w[1] === 1'b1) ndone++;
        end
        chk("repulse extra done", ndone, 0);
        chk("repulse sum", sum_w[1], 32'd3);
        chk("repulse sum_1hop", s1_w[1], 32'd2);
        $display("run repulse: sum=%0d sum_1hop=%0d latency=%0d", $signed(sum_w[1]), $signed(s1_w[1]), lat);

        // Second start clears and recomputes the same values
        run(1, 2, "n2 again");
        chk("n2 again sum", sum_w[1], 32'd3);
        chk("n2 again sum_1hop", s1_w[1], 32'd2);

        // Histogram instance (sums are checked in both builds)
        run(3, 5, "n5");
        chk("n5 sum", sum_w[3], 32'd3);
        chk("n5 sum_1hop", s1_w[3], 32'd2);
        chk("n5 unplaced", unp_w[3], 32'd0);
`ifdef WL_HIST_EN
        chk("hist_d1", h1_w[3], 32'd2);
        chk("hist_d2", h2_w[3], 32'd1);
        chk("hist_d3", h3_w[3], 32'd0);
        chk("hist_dgt3", h4_w[3], 32'd1);
`endif

        // Zero-edge elaboration
        run(4, 0, "n0");
        chk("n0 sum", sum_w[4], 32'd0);
        chk("n0 unplaced", unp_w[4], 32'd0);

        // Reset mid-run at edge 3 of 71
        start_r[2] = 1'b1;
        tick();
        start_r[2] = 1'b0;
        guard = 0;
        while (!(ere_w[2] === 1'b1 && eaddr_w[2] == 9'd3) && guard < 100) begin
            tick();
            guard++;
        end
        chk("abort reached edge 3", 32'(guard < 100), 32'd1);
        reset = 1'b0;
        #2;
        chk("abort sum", sum_w[2], 32'd0);
        chk("abort sum_1hop", s1_w[2], 32'd0);
        chk("abort unplaced", unp_w[2], 32'd0);
        chk("abort busy", 32'(busy_w[2]), 32'd0);
        chk("abort edge_re", 32'(ere_w[2]), 32'd0);
        tick();
        reset = 1'b1;
        ndone = 0;
        repeat (20) begin
            tick();
            if (done_w[2] === 1'b1 || busy_w[2] === 1'b1) ndone++;
        end
        chk("abort stays idle", ndone, 0);
        $display("run abort: reset applied at edge 3");

        // Fresh full run against the reference model
        model(2, 71, es, e1, eu);
        run(2, 71, "n71");
        chk("n71 sum", sum_w[2], 32'(es));
        chk("n71 sum_1hop", s1_w[2], 32'(e1));
        chk("n71 unplaced", unp_w[2], 32'(eu));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/wirelength_eval.md
Name: wirelength_eval

Overview:
- Stage directly downstream of the placement engine.
- Once placement finishes, it walks the edge list (edge A/B ROMs) and reads the X/Y position RAMs for both endpoints of each edge.
- It accumulates the placement cost: the Manhattan wirelength sum and the 1-hop sum.
- This replaces the inline evaluation loop, so placement and evaluation can be verified and retimed independently.

Parameters:
- N_EDGE, 71, number of edges in the netlist.
- EDGE_AW, 9, edge ROM address width.
- POS_AW, 7, position RAM address width.
- DW, 32, data/accumulator width, signed.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins evaluation.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse when results are final.
- edge_re  out  1  edge ROM read strobe, shared by the A and B ROMs.
- edge_addr  out  EDGE_AW  edge index.
- edge_a  in  DW  node A of the addressed edge.
- edge_b  in  DW  node B of the addressed edge.
- pos_re  out  1  read strobe, shared by the X and Y position RAMs.
- pos_addr  out  POS_AW  node index.
- pos_x  in  DW  node X coordinate; -1 means unplaced.
- pos_y  in  DW  node Y coordinate; -1 means unplaced.
- sum  out  DW  sum over edges of (|dx|+|dy|-1).
- sum_1hop  out  DW  sum over edges of (ceil(|dx|/2)+ceil(|dy|/2)-1).
- unplaced_cnt  out  DW  number of edges skipped because an endpoint is unplaced.

Behaviour:
- Reset (asynchronous, active-low): all outputs 0; state IDLE; edge counter i=0.
- Memory timing: edge_re/edge_addr and pos_re/pos_addr are registered outputs, high for exactly one cycle.
  - Memory data is sampled two cycles after the strobe cycle.
  - Strobes are low in every other cycle.
- FSM, one cycle per state:
  - IDLE: on start, clear sum, sum_1hop, unplaced_cnt and i, then go to EDGE. start is ignored in every non-IDLE state.
  - EDGE: edge_re=1, edge_addr=i.
  - EWAIT: wait.
  - RDA: latch edge_b into b_idx; pos_re=1, pos_addr=edge_a.
  - AWAIT: wait.
  - RDB: latch ax=pos_x, ay=pos_y; pos_re=1, pos_addr=b_idx.
  - BWAIT: wait.
  - DIFF: register adx=|ax-pos_x|, ady=|ay-pos_y| using signed subtraction and two's-complement negate. Register the flag skip = (ax==-1)|(ay==-1)|(pos_x==-1)|(pos_y==-1).
  - ACC:
    - If skip, unplaced_cnt += 1.
    - Otherwise sum += adx+ady-1 and sum_1hop += (adx>>1)+adx[0]+(ady>>1)+ady[0]-1.
    - Then i += 1; go to DONE if i==N_EDGE-1, else go to EDGE.
  - DONE: done=1 for one cycle, then go to IDLE.
- Latency: 8 cycles per edge. done asserts 8*N_EDGE+1 cycles after the start cycle.
- Accumulation is signed and wraps modulo 2^DW; there is no saturation.
- An edge with dx=dy=0 legally contributes -1 to both sums.
- N_EDGE==0 is a legal elaboration: start goes IDLE->DONE and done asserts 1 cycle later with all results 0.
- busy: low in IDLE, high in all other states including DONE.
- Results hold their values from done until the next accepted start.
- Reset asserted mid-run aborts immediately. No done is produced, and results read 0.

Optional Feature:
- Macro WL_HIST_EN.
- When defined, four extra DW-wide outputs are present: hist_d1, hist_d2, hist_d3, hist_dgt3.
  - They count non-skipped edges with adx+ady equal to 1, 2, 3, or greater than 3.
  - Edges with distance 0 are not counted.
  - Counters are cleared on start, updated in ACC, and reset to 0.
- When undefined, these ports and counters do not exist. Cycle timing is identical in both builds.

Decomposition:
- Package wl_pkg:
  - State enum.
  - UNPLACED constant = -1.
  - Function abs_dw.
  - Function ceil_half(d) = (d>>1)+d[0].
- One sub-module, wl_accum: holds the DIFF/ACC datapath (abs, ceil-half, accumulators, histogram). The FSM and memory sequencing stay in wirelength_eval.

Test Plan:
- N_EDGE=1; edge 0 = (3,5); pos3=(0,0), pos5=(7,7) -> sum=13, sum_1hop=7, unplaced_cnt=0, done at cycle 9 after start.
- N_EDGE=2; edges (0,1) and (1,2); pos0=(2,2), pos1=(2,3), pos2=(5,2) -> sum=0+3=3, sum_1hop=0+2=2.
- Edge with pos_x of A = -1 -> unplaced_cnt=1; sum and sum_1hop unchanged (0).
- start re-pulsed mid-run -> ignored; done fires once at the expected cycle; a second start after done clears and recomputes identical values.
- reset asserted for 1 cycle at edge 3 of 71 -> all outputs 0 and state IDLE; a fresh start gives the golden-model result for the full run.
- WL_HIST_EN build, distances {1,1,2,4,0} -> hist_d1=2, hist_d2=1, hist_d3=0, hist_dgt3=1.
